// File: rtl/tube_host_regs.sv
// Host-side Tube register pair: a one-byte host-to-parasite latch and a
// parasite-to-host FIFO. PHI2 from the bridge is asynchronous to CLK and is
// resynchronised; host side effects happen on a one-cycle commit pulse.
module tube_host_regs #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TUBE_CS_B,
    input  logic       TUBE_RNW_B,
    input  logic       TUBE_PHI2,
    input  logic       TUBE_ADR0,
    input  logic [7:0] TUBE_DIN,
    output logic [7:0] TUBE_DOUT,
    output logic       TUBE_DOE,
    input  logic       P_WE,
    input  logic       P_RE,
    input  logic [7:0] P_DIN,
    output logic [7:0] P_DOUT,
    output logic [1:0] P_STAT,
    output logic       P_INT_B,
    output logic       TUBE_INT_B
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic          phi2_s1, phi2_s2, phi2_s3;
    logic          commit;
    logic          host_wr_data, host_wr_stat;
    logic          pop, push;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_nxt;
    logic          h2p_full, h2p_full_nxt;
    logic [7:0]    h2p_data;
    logic          h_irq_en, p_irq_en;
    logic          fifo_not_empty;
    logic [7:0]    head, status;

    // Two flops of metastability protection plus one for falling-edge detect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phi2_s1 <= 1'b0;
            phi2_s2 <= 1'b0;
            phi2_s3 <= 1'b0;
        end else begin
            phi2_s1 <= TUBE_PHI2;
            phi2_s2 <= phi2_s1;
            phi2_s3 <= phi2_s2;
        end
    end

    // Bridge holds CS/RnW/ADR0/DIN stable past the PHI2 fall, so they are
    // sampled directly in the commit cycle.
    assign commit       = phi2_s3 & ~phi2_s2 & ~TUBE_CS_B;
    assign host_wr_data = commit & ~TUBE_RNW_B &  TUBE_ADR0;
    assign host_wr_stat = commit & ~TUBE_RNW_B & ~TUBE_ADR0;

    assign fifo_not_empty = (count != '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign pop  = commit & TUBE_RNW_B & TUBE_ADR0 & fifo_not_empty;
    assign push = P_WE & ((count != DEPTH_C) | pop);

    // Next-state values feed both the state registers and the P_STAT register.
    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
        h2p_full_nxt = h2p_full;
        if (host_wr_data)
            h2p_full_nxt = 1'b1;
        else if (P_RE)
            h2p_full_nxt = 1'b0;
    end

    // FIFO storage; contents are never observed while empty, so no reset.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= P_DIN;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // Host-to-parasite latch and interrupt enables.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h2p_full <= 1'b0;
            h2p_data <= 8'h00;
            h_irq_en <= 1'b0;
            p_irq_en <= 1'b0;
        end else begin
            h2p_full <= h2p_full_nxt;
            if (host_wr_data)
                h2p_data <= TUBE_DIN;
            if (host_wr_stat) begin
                h_irq_en <= TUBE_DIN[0];
                p_irq_en <= TUBE_DIN[1];
            end
        end
    end

    // Registered parasite status and interrupts; interrupts lag state by one CLK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P_STAT     <= 2'b01;
            TUBE_INT_B <= 1'b1;
            P_INT_B    <= 1'b1;
        end else begin
            P_STAT     <= {h2p_full_nxt, count_nxt != DEPTH_C};
            TUBE_INT_B <= ~(h_irq_en & fifo_not_empty);
            P_INT_B    <= ~(p_irq_en & h2p_full);
        end
    end

    assign P_DOUT = h2p_data;
    assign head   = fifo_not_empty ? mem[rd_ptr] : 8'h00;
    assign status = {fifo_not_empty, ~h2p_full, 4'b0000, p_irq_en, h_irq_en};

    // Read path is combinational so data is valid inside the PHI2-high window.
    assign TUBE_DOE  = ~TUBE_CS_B & TUBE_RNW_B & TUBE_PHI2;
    assign TUBE_DOUT = TUBE_DOE ? (TUBE_ADR0 ? head : status) : 8'h00;

endmodule

// File: tb/tb_tube_host_regs.sv
// Bench for tube_host_regs: queue-based reference model, per-cycle compare,
// directed scenarios plus randomized host/parasite traffic.
module tb_tube_host_regs;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       TUBE_CS_B = 1'b1, TUBE_RNW_B = 1'b1, TUBE_PHI2 = 1'b0, TUBE_ADR0 = 1'b0;
    logic [7:0] TUBE_DIN = 8'h00;
    logic [7:0] TUBE_DOUT;
    logic       TUBE_DOE;
    logic       P_WE = 1'b0, P_RE = 1'b0;
    logic [7:0] P_DIN = 8'h00;
    logic [7:0] P_DOUT;
    logic [1:0] P_STAT;
    logic       P_INT_B, TUBE_INT_B;

    int checks = 0;
    int errors = 0;

    tube_host_regs #(.DEPTH(DEPTH), .AW(2)) dut (
        .CLK(CLK), .RST(RST),
        .TUBE_CS_B(TUBE_CS_B), .TUBE_RNW_B(TUBE_RNW_B), .TUBE_PHI2(TUBE_PHI2),
        .TUBE_ADR0(TUBE_ADR0), .TUBE_DIN(TUBE_DIN), .TUBE_DOUT(TUBE_DOUT),
        .TUBE_DOE(TUBE_DOE), .P_WE(P_WE), .P_RE(P_RE), .P_DIN(P_DIN),
        .P_DOUT(P_DOUT), .P_STAT(P_STAT), .P_INT_B(P_INT_B), .TUBE_INT_B(TUBE_INT_B)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] q[$];
    logic       m_full = 1'b0, m_hen = 1'b0, m_pen = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_tint = 1'b1, m_pint = 1'b1;
    logic       m_phi_prev = 1'b0;
    int         m_age = 0;      // CLK edges since PHI2 was seen low; commit at 3
    logic       m_cm, m_t_n, m_p_n;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            q.delete();
            m_full = 1'b0; m_data = 8'h00; m_hen = 1'b0; m_pen = 1'b0;
            m_tint = 1'b1; m_pint = 1'b1; m_phi_prev = 1'b0; m_age = 0;
        end else begin
            m_t_n = !(m_hen && q.size() != 0);
            m_p_n = !(m_pen && m_full);
            if (m_age != 0) m_age++;
            else if (m_phi_prev && !TUBE_PHI2) m_age = 1;
            m_phi_prev = TUBE_PHI2;
            m_cm = (m_age == 3) && !TUBE_CS_B;
            if (m_age == 3) m_age = 0;
            if (m_cm && TUBE_RNW_B && TUBE_ADR0 && q.size() > 0) void'(q.pop_front());
            if (P_WE && q.size() < DEPTH) q.push_back(P_DIN);
            if (m_cm && !TUBE_RNW_B && TUBE_ADR0) begin
                m_data = TUBE_DIN; m_full = 1'b1;
            end else if (P_RE) m_full = 1'b0;
            if (m_cm && !TUBE_RNW_B && !TUBE_ADR0) begin
                m_hen = TUBE_DIN[0]; m_pen = TUBE_DIN[1];
            end
            m_tint = m_t_n;
            m_pint = m_p_n;
        end
    end

    function automatic logic [7:0] exp_dout();
        if (!(!TUBE_CS_B && TUBE_RNW_B && TUBE_PHI2)) return 8'h00;
        if (TUBE_ADR0) return (q.size() != 0) ? q[0] : 8'h00;
        return {q.size() != 0, !m_full, 4'b0000, m_pen, m_hen};
    endfunction

    // Per-cycle compare, just after every active edge.
    always @(posedge CLK) begin
        #2;
        chk("p_dout", P_DOUT, m_data);
        chk("p_stat", {6'b0, P_STAT}, {6'b0, m_full, q.size() < DEPTH});
        chk("tube_int_b", {7'b0, TUBE_INT_B}, {7'b0, m_tint});
        chk("p_int_b", {7'b0, P_INT_B}, {7'b0, m_pint});
        chk("tube_doe", {7'b0, TUBE_DOE}, {7'b0, !TUBE_CS_B && TUBE_RNW_B && TUBE_PHI2});
        chk("tube_dout", TUBE_DOUT, exp_dout());
    end

    // ---------------- stimulus helpers ----------------
    // Ends on the negedge where PHI2 has just been driven low; rd is sampled
    // during PHI2 high.
    task automatic host_begin(input logic rnw, input logic adr, input logic [7:0] d,
                              output logic [7:0] rd);
        @(negedge CLK);
        TUBE_CS_B = 1'b0; TUBE_RNW_B = rnw; TUBE_ADR0 = adr; TUBE_DIN = d;
        @(negedge CLK);
        TUBE_PHI2 = 1'b1;
        @(negedge CLK);
        rd = TUBE_DOUT;
        @(negedge CLK);
        TUBE_PHI2 = 1'b0;
    endtask

    task automatic host_release();
        TUBE_CS_B = 1'b1; TUBE_RNW_B = 1'b1;
    endtask

    task automatic host(input logic rnw, input logic adr, input logic [7:0] d,
                        output logic [7:0] rd);
        host_begin(rnw, adr, d, rd);
        repeat (3) @(negedge CLK);
        host_release();
    endtask

    task automatic pwrite(input logic [7:0] d);
        @(negedge CLK); P_WE = 1'b1; P_DIN = d;
        @(negedge CLK); P_WE = 1'b0;
    endtask

    task automatic pread();
        @(negedge CLK); P_RE = 1'b1;
        @(negedge CLK); P_RE = 1'b0;
    endtask

    logic [7:0] rd;
    logic       hdone = 1'b0;

    initial begin
        // async reset before any clock edge
        #2 RST = 1'b1;
        #1;
        chk("rst_tube_dout", TUBE_DOUT, 8'h00);
        chk("rst_tube_doe", {7'b0, TUBE_DOE}, 8'h00);
        chk("rst_p_dout", P_DOUT, 8'h00);
        chk("rst_p_stat", {6'b0, P_STAT}, 8'h01);
        chk("rst_p_int_b", {7'b0, P_INT_B}, 8'h01);
        chk("rst_tube_int_b", {7'b0, TUBE_INT_B}, 8'h01);
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // H2P path with latency pinning
        host_begin(1'b0, 1'b1, 8'hA5, rd);
        @(negedge CLK);
        @(negedge CLK);
        chk("h2p_before_commit", P_DOUT, 8'h00);
        @(negedge CLK);
        chk("h2p_data", P_DOUT, 8'hA5);
        chk("h2p_full", {6'b0, P_STAT}, 8'h03);
        host_release();
        host(1'b1, 1'b0, 8'h00, rd);
        chk("status_full_bit6", {7'b0, rd[6]}, 8'h00);
        pread();
        chk("h2p_cleared", {6'b0, P_STAT}, 8'h01);
        host(1'b1, 1'b0, 8'h00, rd);
        chk("status_empty_bit6", {7'b0, rd[6]}, 8'h01);
        chk("p_dout_holds", P_DOUT, 8'hA5);

        // FIFO fill / drain
        pwrite(8'h11); pwrite(8'h22); pwrite(8'h33);
        chk("fifo_3_not_full", {7'b0, P_STAT[0]}, 8'h01);
        pwrite(8'h44);
        chk("fifo_4_full", {7'b0, P_STAT[0]}, 8'h00);
        pwrite(8'h55);
        host(1'b1, 1'b1, 8'h00, rd); chk("drain0", rd, 8'h11);
        host(1'b1, 1'b1, 8'h00, rd); chk("drain1", rd, 8'h22);
        host(1'b1, 1'b1, 8'h00, rd); chk("drain2", rd, 8'h33);
        host(1'b1, 1'b1, 8'h00, rd); chk("drain3", rd, 8'h44);
        host(1'b1, 1'b1, 8'h00, rd); chk("drain_empty", rd, 8'h00);
        host(1'b1, 1'b0, 8'h00, rd); chk("status_bit7_empty", {7'b0, rd[7]}, 8'h00);

        // Pointer wrap with occupancy up to 4
        pwrite(8'h20); pwrite(8'h21); pwrite(8'h22);
        for (int i = 3; i < 13; i++) begin
            pwrite(8'h20 + 8'(i));
            host(1'b1, 1'b1, 8'h00, rd);
            chk("wrap_order", rd, 8'h20 + 8'(i - 3));
        end
        for (int i = 10; i < 13; i++) begin
            host(1'b1, 1'b1, 8'h00, rd);
            chk("wrap_tail", rd, 8'h20 + 8'(i));
        end

        // Interrupts
        host(1'b0, 1'b0, 8'h03, rd);
        pwrite(8'h7E);
        chk("tint_lag", {7'b0, TUBE_INT_B}, 8'h01);
        @(negedge CLK);
        chk("tint_low", {7'b0, TUBE_INT_B}, 8'h00);
        host(1'b1, 1'b1, 8'h00, rd);
        chk("tint_pop_data", rd, 8'h7E);
        @(negedge CLK);
        chk("tint_high", {7'b0, TUBE_INT_B}, 8'h01);
        host(1'b0, 1'b1, 8'h5A, rd);
        @(negedge CLK);
        chk("pint_low", {7'b0, P_INT_B}, 8'h00);
        pread();
        @(negedge CLK);
        chk("pint_high", {7'b0, P_INT_B}, 8'h01);
        host(1'b0, 1'b0, 8'h00, rd);

        // Collision: host data write commit with P_RE in the same CLK
        host_begin(1'b0, 1'b1, 8'hC3, rd);
        @(negedge CLK);
        @(negedge CLK); P_RE = 1'b1;
        @(negedge CLK); P_RE = 1'b0;
        chk("coll_wr_data", P_DOUT, 8'hC3);
        chk("coll_wr_full", {7'b0, P_STAT[1]}, 8'h01);
        host_release();
        pread();

        // Collision: push and pop at count 4
        pwrite(8'hA0); pwrite(8'hA1); pwrite(8'hA2); pwrite(8'hA3);
        host_begin(1'b1, 1'b1, 8'h00, rd);
        chk("coll_head", rd, 8'hA0);
        @(negedge CLK);
        @(negedge CLK); P_WE = 1'b1; P_DIN = 8'h99;
        @(negedge CLK); P_WE = 1'b0;
        chk("coll_still_full", {7'b0, P_STAT[0]}, 8'h00);
        host_release();
        host(1'b1, 1'b1, 8'h00, rd); chk("coll_d1", rd, 8'hA1);
        host(1'b1, 1'b1, 8'h00, rd); chk("coll_d2", rd, 8'hA2);
        host(1'b1, 1'b1, 8'h00, rd); chk("coll_d3", rd, 8'hA3);
        host(1'b1, 1'b1, 8'h00, rd); chk("coll_d4", rd, 8'h99);

        // Randomized traffic on both sides
        fork
            begin
                while (!hdone) begin
                    @(negedge CLK);
                    P_WE  = ($urandom % 3) == 0;
                    P_RE  = ($urandom % 5) == 0;
                    P_DIN = 8'($urandom);
                end
                P_WE = 1'b0; P_RE = 1'b0;
            end
            begin
                for (int n = 0; n < 150; n++) begin
                    host(1'($urandom), 1'($urandom), 8'($urandom), rd);
                    repeat ($urandom_range(0, 3)) @(negedge CLK);
                end
                hdone = 1'b1;
            end
        join

        // Reset in the middle of a host data write: nothing survives
        pwrite(8'h66);
        host_begin(1'b0, 1'b1, 8'hEE, rd);
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("midrst_p_dout", P_DOUT, 8'h00);
        chk("midrst_p_stat", {6'b0, P_STAT}, 8'h01);
        chk("midrst_tint", {7'b0, TUBE_INT_B}, 8'h01);
        chk("midrst_pint", {7'b0, P_INT_B}, 8'h01);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        host_release();
        chk("midrst_no_commit", P_DOUT, 8'h00);
        host(1'b1, 1'b0, 8'h00, rd);
        chk("midrst_status", rd, 8'h40);
        repeat (2) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
